axi_ram_ctrl: RTL

AXI4 slave front-end that sits directly upstream of the behavioural single-port `ram` model in the AXI memory testbench. It accepts AXI4 read and write bursts from the DUT's memory port and sequences them into per-beat RAM accesses: word address, enable and byte strobe. It also returns the RAM's 1-cycle-latency read data on the R channel with full backpressure support. Only one burst is serviced at a time.

---
 rtl/axi_ram_pkg.sv | 47 ++++
 rtl/axi_ram_rbuf.sv | 69 ++++++
 rtl/axi_ram_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg
// Shared types and helpers for the AXI-to-RAM controller:
//   burst_e        AXI burst encodings (FIXED / INCR / WRAP)
//   RESP_*         AXI response codes used by this controller
//   state_e        controller FSM states
//   next_beat_addr byte address of the following beat of a burst
package axi_ram_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_DATA = 2'd1,
        S_WR_RESP = 2'd2,
        S_RD_DATA = 2'd3
    } state_e;

    // Computed on a 64-bit address so one function serves any ADDR_WD;
    // callers truncate the result. Reserved burst 2'b11 falls into INCR.
    function automatic logic [63:0] next_beat_addr(
        input logic [63:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [63:0] step;
        logic [63:0] span;
        logic [63:0] mask;
        step = 64'd1 << size;
        span = ({56'd0, len} + 64'd1) << size;
        mask = span - 64'd1;
        case (burst)
            BURST_FIXED: next_beat_addr = addr;
            // Keep the aligned-down window base, wrap the offset inside it.
            BURST_WRAP:  next_beat_addr = (addr & ~mask) | ((addr + step) & mask);
            default:     next_beat_addr = addr + step;
        endcase
    endfunction

endpackage

// File: rtl/axi_ram_rbuf.sv
// axi_ram_rbuf
// Two-entry fall-through FIFO for the R channel, carrying {rlast, rdata}.
// When empty, a pushed word is presented on the same cycle (so RAM data
// reaches rvalid one cycle after the RAM read) and is consumed directly if
// popped; otherwise it is stored. count feeds the read-issue credit check.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   push, push_data/last      word returning from the RAM
//   pop                       R handshake (rvalid & rready)
//   rvalid, rdata, rlast      head of queue
//   count                     stored entries (0..2)
module axi_ram_rbuf
    import axi_ram_pkg::*;
#(
    parameter int DATA_WD = 128
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic [DATA_WD-1:0] push_data,
    input  logic               push_last,
    input  logic               pop,
    output logic               rvalid,
    output logic [DATA_WD-1:0] rdata,
    output logic               rlast,
    output logic [1:0]         count
);

    logic [DATA_WD:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             empty;
    logic             bypass;
    logic             store;
    logic             take;

    assign empty  = (count == 2'd0);
    assign bypass = empty && push && pop;
    assign store  = push && !bypass;
    assign take   = pop && !empty;
    assign rvalid = !empty || push;

    always_comb begin
        {rlast, rdata} = '0;
        if (!empty)
            {rlast, rdata} = mem[rd_ptr];
        else if (push)
            {rlast, rdata} = {push_last, push_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= !wr_ptr;
            end
            if (take)
                rd_ptr <= !rd_ptr;
            count <= count + {1'b0, store} - {1'b0, take};
        end
    end

endmodule

// File: rtl/axi_ram_ctrl.sv
// axi_ram_ctrl
// AXI4 slave that turns one read or write burst at a time into per-beat
// accesses on a single-port RAM with 1-cycle read latency.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   aw*/w*/b*                       AXI write address / data / response
//   ar*/r*                          AXI read address / data
//   ram_addr                        RAM word address (byte addr >> log2(DATA_WD/8))
//   ram_wr_en, ram_rd_en            RAM enables (never both high)
//   ram_strobe, ram_w_data          RAM write byte strobe / data
//   ram_r_data                      RAM read data, valid the cycle after ram_rd_en
//   dbg_state                       current FSM state (state_e encoding)
// Handshakes: a transfer occurs on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until that edge.
// awready/arready are high only in IDLE for the granted request.
// Optional feature macro: AXI_RAM_RANGE_CHECK_EN -- bursts starting at or
// beyond MEM_SIZE MiB get DECERR, with RAM enables suppressed and reads
// returning zero data.
module axi_ram_ctrl
    import axi_ram_pkg::*;
#(
    parameter int DATA_WD  = 128,
    parameter int ADDR_WD  = 32,
    parameter int ID_WD    = 4,
    parameter int MEM_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [ID_WD-1:0]     awid,
    input  logic [ADDR_WD-1:0]   awaddr,
    input  logic [7:0]           awlen,
    input  logic [2:0]           awsize,
    input  logic [1:0]           awburst,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [DATA_WD-1:0]   wdata,
    input  logic [DATA_WD/8-1:0] wstrb,
    input  logic                 wlast,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [ID_WD-1:0]     bid,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic [ID_WD-1:0]     arid,
    input  logic [ADDR_WD-1:0]   araddr,
    input  logic [7:0]           arlen,
    input  logic [2:0]           arsize,
    input  logic [1:0]           arburst,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [ID_WD-1:0]     rid,
    output logic [DATA_WD-1:0]   rdata,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [ADDR_WD-1:0]   ram_addr,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic [DATA_WD/8-1:0] ram_strobe,
    output logic [DATA_WD-1:0]   ram_w_data,
    input  logic [DATA_WD-1:0]   ram_r_data,
    output logic [1:0]           dbg_state
);

    localparam int WORD_SHIFT = $clog2(DATA_WD / 8);

    if (DATA_WD < 32 || (DATA_WD & (DATA_WD - 1)) != 0 || MEM_SIZE < 1) begin : g_bad_param
        $error("axi_ram_ctrl: DATA_WD must be a power of two >= 32 and MEM_SIZE >= 1");
    end

    state_e             state, state_n;
    logic               last_grant_wr;
    logic [ID_WD-1:0]   id_q;
    logic [ADDR_WD-1:0] beat_addr;
    logic [ADDR_WD-1:0] next_addr;
    logic [7:0]         len_q;
    logic [7:0]         beat_cnt;
    logic [2:0]         size_q;
    logic [1:0]         burst_q;
    logic               oor;
    logic               issue_done;
    logic               inflight;
    logic               inflight_last;
    logic [1:0]         rb_count;
    logic               grant_wr, grant_rd;
    logic               aw_hs, ar_hs, w_beat, issue, pop;

    // Alternate on contention; last_grant_wr=0 after reset so write wins first.
    assign grant_wr = awvalid && (!arvalid || !last_grant_wr);
    assign grant_rd = arvalid && !grant_wr;
    assign aw_hs    = awvalid && awready;
    assign ar_hs    = arvalid && arready;
    assign w_beat   = wvalid && wready;
    assign pop      = rvalid && rready;

    assign next_addr = ADDR_WD'(next_beat_addr(64'(beat_addr), size_q, len_q, burst_q));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        issue   = 1'b0;
        case (state)
            S_IDLE: begin
                awready = grant_wr;
                arready = grant_rd;
                if (grant_wr)      state_n = S_WR_DATA;
                else if (grant_rd) state_n = S_RD_DATA;
            end
            S_WR_DATA: begin
                wready = 1'b1;
                // Premature wlast ends the burst; a missing one is covered by the count.
                if (wvalid && (wlast || beat_cnt == len_q)) state_n = S_WR_RESP;
            end
            S_WR_RESP: begin
                bvalid = 1'b1;
                if (bready) state_n = S_IDLE;
            end
            S_RD_DATA: begin
                // Issue only while buffered + in-flight words after this pop stay below 2.
                issue = !issue_done &&
                        (({1'b0, rb_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
                if (pop && rlast) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_wr <= 1'b0;
            id_q          <= '0;
            beat_addr     <= '0;
            len_q         <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            beat_cnt      <= '0;
            issue_done    <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (aw_hs) begin
                id_q <= awid; beat_addr <= awaddr; len_q <= awlen;
                size_q <= awsize; burst_q <= awburst; last_grant_wr <= 1'b1;
            end else if (ar_hs) begin
                id_q <= arid; beat_addr <= araddr; len_q <= arlen;
                size_q <= arsize; burst_q <= arburst; last_grant_wr <= 1'b0;
            end else if (w_beat || issue) begin
                beat_addr <= next_addr;
            end
            if (aw_hs || ar_hs) begin
                beat_cnt   <= '0;
                issue_done <= 1'b0;
            end else if (w_beat || issue) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (beat_cnt == len_q) issue_done <= 1'b1;
            end
            inflight      <= issue;
            inflight_last <= issue && (beat_cnt == len_q);
        end
    end

`ifdef AXI_RAM_RANGE_CHECK_EN
    localparam logic [63:0] MEM_BYTES = 64'(MEM_SIZE) << 20;
    logic [ADDR_WD-1:0] start_addr;
    assign start_addr = aw_hs ? awaddr : araddr;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)               oor <= 1'b0;
        else if (aw_hs || ar_hs) oor <= (64'(start_addr) >= MEM_BYTES);
    end
`else
    assign oor = 1'b0;
`endif

    axi_ram_rbuf #(.DATA_WD(DATA_WD)) u_rbuf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight),
        .push_data (oor ? '0 : ram_r_data),
        .push_last (inflight_last),
        .pop       (pop),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rlast     (rlast),
        .count     (rb_count)
    );

    assign ram_addr   = beat_addr >> WORD_SHIFT;
    assign ram_wr_en  = w_beat && !oor;
    assign ram_rd_en  = issue && !oor;
    assign ram_strobe = wready ? wstrb : '0;
    assign ram_w_data = wready ? wdata : '0;
    assign bid        = id_q;
    assign rid        = id_q;
    assign bresp      = oor ? RESP_DECERR : RESP_OKAY;
    assign rresp      = oor ? RESP_DECERR : RESP_OKAY;
    assign dbg_state  = state;

endmodule
